// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundle of the two writeback request channels and the register-file write
// port served by regfile_wb_arbiter.
//   alu_valid/alu_reg/alu_data  -> ALU writeback request, alu_ready <- grant
//   mdu_valid/mdu_reg/mdu_data  -> MDU writeback request, mdu_ready <- grant
//   WB/writeReg/writeData       <- registered register-file write port
//   wb_src                      <- source of the current WB pulse (0 ALU, 1 MDU)
//   mdu_stall_cnt               <- saturating count of blocked MDU cycles
// master: the side presenting requests; slave: the arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              WB;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              wb_src;
    logic [CNT_W-1:0]  mdu_stall_cnt;

    modport master (
        output alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data,
        input  alu_ready, mdu_ready, WB, writeReg, writeData, wb_src, mdu_stall_cnt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data,
        output alu_ready, mdu_ready, WB, writeReg, writeData, wb_src, mdu_stall_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU pipeline
// (fixed priority) and the multi-cycle MDU. An aging counter hands priority
// to the MDU once it has been blocked AGE_LIMIT consecutive cycles; priority
// returns to the ALU after the MDU transfer (or if the MDU withdraws).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave: request channels (ready is
//          combinational from state and the valids only), registered write
//          port WB/writeReg/writeData/wb_src, and mdu_stall_cnt.
// Widths on the interface instance must match DATA_W/ADDR_W/CNT_W here.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int AGE_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_AGED   = 1'b1
    } state_t;

    localparam logic [3:0]        AGE_LIM_C = 4'(AGE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] REG_ZERO  = {ADDR_W{1'b0}};

    state_t              state_q, state_d;
    logic [3:0]          age_q, age_d;
    logic                wb_q, wb_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                wb_src_q, wb_src_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic                alu_ready_s, mdu_ready_s;
    logic                alu_xfer_s, mdu_xfer_s, mdu_blocked_s;

    // Grant: the priority owner is always ready, the other side only while the owner is idle.
    always_comb begin
        alu_ready_s = 1'b1;
        mdu_ready_s = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                alu_ready_s = 1'b1;
                mdu_ready_s = !bus.alu_valid;
            end
            ST_AGED: begin
                mdu_ready_s = 1'b1;
                alu_ready_s = !bus.mdu_valid;
            end
            default: begin
                alu_ready_s = 1'b1;
                mdu_ready_s = !bus.alu_valid;
            end
        endcase
    end

    assign alu_xfer_s    = bus.alu_valid & alu_ready_s;
    assign mdu_xfer_s    = bus.mdu_valid & mdu_ready_s;
    assign mdu_blocked_s = bus.mdu_valid & ~mdu_ready_s;

    // Priority state and aging counter; age only advances while MDU is blocked in NORMAL.
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        case (state_q)
            ST_NORMAL: begin
                if (!bus.mdu_valid || mdu_xfer_s) begin
                    age_d = 4'd0;
                end else if (mdu_blocked_s) begin
                    age_d = age_q + 4'd1;
                    if ((age_q + 4'd1) == AGE_LIM_C) begin
                        state_d = ST_AGED;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end else begin
                    age_d = age_q;
                end
            end
            ST_AGED: begin
                // Withdrawal of mdu_valid also drops priority so ALU is never starved.
                if (mdu_xfer_s || !bus.mdu_valid) begin
                    state_d = ST_NORMAL;
                    age_d   = 4'd0;
                end else begin
                    state_d = ST_AGED;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                age_d   = 4'd0;
            end
        endcase
    end

    // Write port: a transfer loads address/data/source; WB is suppressed for register 0.
    always_comb begin
        wb_d         = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        wb_src_d     = wb_src_q;
        if (alu_xfer_s) begin
            wb_d         = (bus.alu_reg != REG_ZERO);
            write_reg_d  = bus.alu_reg;
            write_data_d = bus.alu_data;
            wb_src_d     = 1'b0;
        end else if (mdu_xfer_s) begin
            wb_d         = (bus.mdu_reg != REG_ZERO);
            write_reg_d  = bus.mdu_reg;
            write_data_d = bus.mdu_data;
            wb_src_d     = 1'b1;
        end else begin
            wb_d = 1'b0;
        end
    end

    // Saturating statistics counter of blocked MDU cycles.
    always_comb begin
        if (mdu_blocked_s && (stall_cnt_q != CNT_MAX_C)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE_C;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            age_q        <= 4'd0;
            wb_q         <= 1'b0;
            write_reg_q  <= {ADDR_W{1'b0}};
            write_data_q <= {DATA_W{1'b0}};
            wb_src_q     <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            age_q        <= age_d;
            wb_q         <= wb_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            wb_src_q     <= wb_src_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.alu_ready     = alu_ready_s;
    assign bus.mdu_ready     = mdu_ready_s;
    assign bus.WB            = wb_q;
    assign bus.writeReg      = write_reg_q;
    assign bus.writeData     = write_data_q;
    assign bus.wb_src        = wb_src_q;
    assign bus.mdu_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Randomized and directed stimulus against a behavioural model of the
// arbiter: priority goes to the MDU once it has waited AGE_LIMIT consecutive
// blocked cycles, otherwise to the ALU. A second instance with a 4-bit stall
// counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int AGE_LIMIT = 4;
    localparam int CNT_W     = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   chk_en;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))     bus4 ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AGE_LIMIT(AGE_LIMIT), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AGE_LIMIT(AGE_LIMIT), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    assign bus4.alu_valid = bus.alu_valid;
    assign bus4.alu_reg   = bus.alu_reg;
    assign bus4.alu_data  = bus.alu_data;
    assign bus4.mdu_valid = bus.mdu_valid;
    assign bus4.mdu_reg   = bus.mdu_reg;
    assign bus4.mdu_data  = bus.mdu_data;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int              wait_r       = 0;   // consecutive cycles M has been refused
    bit              exp_wb_r     = 1'b0;
    logic [4:0]      exp_reg_r    = 5'd0;
    logic [31:0]     exp_data_r   = 32'd0;
    bit              exp_src_r    = 1'b0;
    int              exp_stall_r  = 0;
    int              exp_stall4_r = 0;
    bit              m_prio_s, exp_alu_ready_s, exp_mdu_ready_s, ga_s, gm_s;

    // Who may write this cycle: M once it has waited long enough, otherwise A.
    always_comb begin
        m_prio_s        = (wait_r >= AGE_LIMIT);
        exp_alu_ready_s = !(m_prio_s && bus.mdu_valid);
        exp_mdu_ready_s = m_prio_s || !bus.alu_valid;
        ga_s            = bus.alu_valid && exp_alu_ready_s;
        gm_s            = bus.mdu_valid && exp_mdu_ready_s;
    end

    // Model state update at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_r       <= 0;
            exp_wb_r     <= 1'b0;
            exp_reg_r    <= 5'd0;
            exp_data_r   <= 32'd0;
            exp_src_r    <= 1'b0;
            exp_stall_r  <= 0;
            exp_stall4_r <= 0;
        end else begin
            if (gm_s || !bus.mdu_valid) wait_r <= 0;
            else                        wait_r <= wait_r + 1;
            if (bus.mdu_valid && !gm_s) begin
                exp_stall_r  <= (exp_stall_r  < 65535) ? exp_stall_r + 1  : 65535;
                exp_stall4_r <= (exp_stall4_r < 15)    ? exp_stall4_r + 1 : 15;
            end
            if (ga_s) begin
                exp_wb_r   <= (bus.alu_reg != 5'd0);
                exp_reg_r  <= bus.alu_reg;
                exp_data_r <= bus.alu_data;
                exp_src_r  <= 1'b0;
            end else if (gm_s) begin
                exp_wb_r   <= (bus.mdu_reg != 5'd0);
                exp_reg_r  <= bus.mdu_reg;
                exp_data_r <= bus.mdu_data;
                exp_src_r  <= 1'b1;
            end else begin
                exp_wb_r   <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n === 1'b1) begin
            chk("alu_ready", {63'd0, bus.alu_ready}, {63'd0, exp_alu_ready_s});
            chk("mdu_ready", {63'd0, bus.mdu_ready}, {63'd0, exp_mdu_ready_s});
            chk("one_grant", {63'd0, bus.alu_valid & bus.alu_ready & bus.mdu_valid & bus.mdu_ready}, 64'd0);
            chk("WB", {63'd0, bus.WB}, {63'd0, exp_wb_r});
            chk("writeReg", {59'd0, bus.writeReg}, {59'd0, exp_reg_r});
            chk("writeData", {32'd0, bus.writeData}, {32'd0, exp_data_r});
            chk("wb_src", {63'd0, bus.wb_src}, {63'd0, exp_src_r});
            chk("stall_cnt", {48'd0, bus.mdu_stall_cnt}, 64'(exp_stall_r));
            chk("stall_cnt4", {60'd0, bus4.mdu_stall_cnt}, 64'(exp_stall4_r));
            chk("WB_4", {63'd0, bus4.WB}, {63'd0, exp_wb_r});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
    endtask

    // Protocol-respecting random traffic: requests hold until transferred.
    task automatic run_random(input int n);
        bit xa, xm;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xa = bus.alu_valid && bus.alu_ready;
            xm = bus.mdu_valid && bus.mdu_ready;
            step();
            if (!bus.alu_valid || xa) begin
                bus.alu_valid = ($urandom_range(0, 3) != 0);
                bus.alu_reg   = 5'($urandom_range(0, 31));
                bus.alu_data  = $urandom;
            end
            if (!bus.mdu_valid || xm) begin
                bus.mdu_valid = ($urandom_range(0, 1) != 0);
                bus.mdu_reg   = 5'($urandom_range(0, 31));
                bus.mdu_data  = $urandom;
            end
        end
        step();
        idle_inputs();
        step();
    endtask

    // Assert reset away from the clock edge and check the outputs clear at once.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_WB", {63'd0, bus.WB}, 64'd0);
        chk("rst_writeReg", {59'd0, bus.writeReg}, 64'd0);
        chk("rst_writeData", {32'd0, bus.writeData}, 64'd0);
        chk("rst_wb_src", {63'd0, bus.wb_src}, 64'd0);
        chk("rst_stall", {48'd0, bus.mdu_stall_cnt}, 64'd0);
        chk("rst_stall4", {60'd0, bus4.mdu_stall_cnt}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [4:0] pulse_regs [6];
    bit         exp_ar [6];
    bit         exp_mr [6];

    initial begin
        bit xa, xm;
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_reg = 5'd0; bus.alu_data = 32'd0;
        bus.mdu_valid = 1'b0; bus.mdu_reg = 5'd0; bus.mdu_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single ALU write, M idle.
        step();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'd50;
        @(negedge clk);
        chk("d_alu_ready", {63'd0, bus.alu_ready}, 64'd1);
        step();
        bus.alu_valid = 1'b0;
        chk("d_alu_WB", {63'd0, bus.WB}, 64'd1);
        chk("d_alu_reg", {59'd0, bus.writeReg}, 64'd20);
        chk("d_alu_data", {32'd0, bus.writeData}, 64'd50);
        chk("d_alu_src", {63'd0, bus.wb_src}, 64'd0);
        chk("d_model_reg", {59'd0, exp_reg_r}, 64'd20);
        step();
        chk("d_alu_WB_off", {63'd0, bus.WB}, 64'd0);

        // Single MDU write, A idle.
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd7; bus.mdu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("d_mdu_ready", {63'd0, bus.mdu_ready}, 64'd1);
        step();
        bus.mdu_valid = 1'b0;
        chk("d_mdu_WB", {63'd0, bus.WB}, 64'd1);
        chk("d_mdu_reg", {59'd0, bus.writeReg}, 64'd7);
        chk("d_mdu_data", {32'd0, bus.writeData}, 64'hDEADBEEF);
        chk("d_mdu_src", {63'd0, bus.wb_src}, 64'd1);
        chk("d_model_src", {63'd0, exp_src_r}, 64'd1);
        step();

        // Register 0 is accepted but never written.
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'd123;
        @(negedge clk);
        chk("d_r0_ready", {63'd0, bus.alu_ready}, 64'd1);
        step();
        bus.alu_valid = 1'b0;
        chk("d_r0_WB", {63'd0, bus.WB}, 64'd0);
        chk("d_r0_reg", {59'd0, bus.writeReg}, 64'd0);
        chk("d_r0_data", {32'd0, bus.writeData}, 64'd123);
        step();

        run_random(1500);
        reset_mid();

        // Aging: A streams regs 1,2,3,..., M waits with reg 9.
        pulse_regs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5};
        exp_ar     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_mr     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        step();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h100;
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd9; bus.mdu_data = 32'h900;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("age_alu_ready", {63'd0, bus.alu_ready}, {63'd0, exp_ar[c]});
            chk("age_mdu_ready", {63'd0, bus.mdu_ready}, {63'd0, exp_mr[c]});
            xa = bus.alu_valid && bus.alu_ready;
            xm = bus.mdu_valid && bus.mdu_ready;
            step();
            chk("age_WB", {63'd0, bus.WB}, 64'd1);
            chk("age_reg", {59'd0, bus.writeReg}, {59'd0, pulse_regs[c]});
            chk("age_src", {63'd0, bus.wb_src}, (c == 4) ? 64'd1 : 64'd0);
            if (xa) begin
                bus.alu_reg  = bus.alu_reg + 5'd1;
                bus.alu_data = bus.alu_data + 32'd1;
            end
            if (xm) bus.mdu_valid = 1'b0;
        end
        bus.alu_valid = 1'b0;
        chk("age_stall", {48'd0, bus.mdu_stall_cnt}, 64'd4);

        // Sustained blocking: 20 cycles give 16 more blocked cycles.
        step();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd11;
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            xa = bus.alu_valid && bus.alu_ready;
            xm = bus.mdu_valid && bus.mdu_ready;
            step();
            if (xa) bus.alu_data = $urandom;
            if (xm) bus.mdu_data = $urandom;
        end
        chk("sat_stall16", {48'd0, bus.mdu_stall_cnt}, 64'd20);
        chk("sat_stall4", {60'd0, bus4.mdu_stall_cnt}, 64'd15);
        idle_inputs();
        step();

        run_random(1500);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WB / writeReg / writeData) between two writeback sources: the ALU pipeline (port A) and the multi-cycle multiply/divide unit (port M).
- Port A has fixed priority. An aging counter forces a grant to M once M has waited AGE_LIMIT cycles.
- The write-port outputs are registered and drive the register file's WB, writeReg and writeData inputs directly.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width (32 registers).
- AGE_LIMIT, 4, number of consecutive blocked cycles for M before M gets forced priority (legal range 1..15).
- CNT_W, 16, width of the saturating stall statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mdu_valid  in  1  MDU writeback request.
- mdu_reg  in  ADDR_W  MDU destination register.
- mdu_data  in  DATA_W  MDU result.
- mdu_ready  out  1  MDU request accepted this cycle (combinational).
- WB  out  1  register-file write enable, registered, one-cycle pulse per write.
- writeReg  out  ADDR_W  register-file write address, registered.
- writeData  out  DATA_W  register-file write data, registered.
- wb_src  out  1  source of the current WB pulse (0 = ALU, 1 = MDU), registered.
- mdu_stall_cnt  out  CNT_W  saturating count of cycles where mdu_valid=1 and mdu_ready=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=NORMAL, age_cnt=0.
  - WB=0, writeReg=0, writeData=0, wb_src=0, mdu_stall_cnt=0.
  - Outputs clear immediately, without waiting for a clock edge.
- Handshake:
  - A transfer occurs on a port when valid=1 and ready=1 at a rising clk edge.
  - A source must hold valid, reg and data stable until its transfer.
  - ready may depend on valid of either port but never on reg or data.
- FSM states:
  - NORMAL (ALU priority): alu_ready=1; mdu_ready = !alu_valid.
  - AGED (MDU priority): mdu_ready=1; alu_ready = !mdu_valid.
  - Exactly one transfer per cycle maximum; no cycle ever grants both ports.
- age_cnt (4 bits):
  - In NORMAL: increments each cycle with mdu_valid=1 and mdu_ready=0.
  - Cleared on any M transfer, and cleared whenever mdu_valid=0.
- Transitions:
  - NORMAL -> AGED at the edge where the incremented age_cnt equals AGE_LIMIT.
  - AGED -> NORMAL on an M transfer, or if mdu_valid drops (defensive). age_cnt is cleared on this transition.
- Write port:
  - On a transfer at edge N: WB=1, writeReg=src reg, writeData=src data, wb_src=src, all updated at edge N.
  - These values are visible for the cycle after edge N (latency 1).
  - With no transfer: WB=0; writeReg, writeData and wb_src hold their last values.
- Register 0:
  - A transfer with reg=0 is accepted (ready as normal) but WB stays 0.
  - writeReg, writeData and wb_src still update.
- mdu_stall_cnt increments on each blocked M cycle and saturates at all-ones; it is never cleared except by reset.
- Back-to-back:
  - Consecutive transfers produce consecutive WB pulses, one per cycle, with no bubble.
  - Throughput is 1 write per cycle.
- Reset mid-operation: in-flight requests are not retained; sources re-present after reset is released.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle -> WB, writeReg, writeData and mdu_stall_cnt go to 0 asynchronously; state=NORMAL.
- alu_valid=1, alu_reg=20, alu_data=50 for one cycle, M idle -> alu_ready=1; next cycle WB=1, writeReg=20, writeData=50, wb_src=0; the cycle after, WB=0.
- mdu_valid=1, reg=7, data=0xDEADBEEF with M alone -> mdu_ready=1 in the same cycle; next cycle WB=1, writeReg=7, wb_src=1.
- alu_valid held 1 (regs 1,2,3,...) with mdu_valid=1, reg=9, AGE_LIMIT=4:
  - M is blocked 4 cycles; 5th cycle mdu_ready=1 and alu_ready=0.
  - WB pulses carry regs 1,2,3,4 (wb_src=0), then 9 (wb_src=1), then ALU resumes.
  - mdu_stall_cnt=4.
- alu transfer with reg=0, data=123 -> alu_ready=1; next cycle WB=0, writeReg=0, writeData=123.
- Force mdu_stall_cnt near all-ones (CNT_W=4 build) with continued blocking -> counter stops at 15.
